// File: rtl/adder45_arbiter.sv
// ---------------------------------------------------------------------------
// adder45_arbiter
//
// Shares one 45-bit unsigned ripple-carry adder between NUM_REQ requesters.
// One request is granted at a time. Its operands are registered so that the
// ripple chain gets a full cycle, and the 46-bit sum is returned with the
// owner's index over a valid/ready response port. Only one addition is in
// flight at any time: IDLE (grant) -> EXEC (add) -> RESP (hand off).
//
// Build option:
//   ADD45_ARB_RR_EN  defined   : round-robin grant starting at a rotating
//                                pointer that moves past the last winner.
//                    undefined : fixed priority; lowest valid index wins and
//                                no pointer register exists.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_req_valid    [NUM_REQ]     per-requester request valid
//   o_req_ready    [NUM_REQ]     per-requester accept, one-hot or zero
//   i_req_a        [NUM_REQ*45]  packed A operands, requester i at [45*i +: 45]
//   i_req_b        [NUM_REQ*10]  packed B operands, requester i at [10*i +: 10]
//   o_rsp_valid    result valid
//   i_rsp_ready    downstream accepts result
//   o_rsp_id       [ID_W]  index of the requester owning the result
//   o_rsp_sum      [46]    A + zero-extended B
// ---------------------------------------------------------------------------

// Plain 45-bit ripple-carry adder; the carry out becomes the 46th sum bit.
module unsignedRippleCarryAdder45bit (
  input  logic [44:0] i_a,
  input  logic [44:0] i_b,
  output logic [45:0] o_sum
);

  logic [45:0] w_carry;

  assign w_carry[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 45; gi++) begin : g_fullAdder
      assign o_sum[gi]       = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
      assign w_carry[gi + 1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
    end
  endgenerate

  assign o_sum[45] = w_carry[45];

endmodule

module adder45_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  output logic [NUM_REQ-1:0]    o_req_ready,
  input  logic [NUM_REQ*45-1:0] i_req_a,
  input  logic [NUM_REQ*10-1:0] i_req_b,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [ID_W-1:0]       o_rsp_id,
  output logic [45:0]           o_rsp_sum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [44:0]     r_opA;
  logic [9:0]      r_opB;
  logic [ID_W-1:0] r_opId;
  logic [ID_W-1:0] r_rspId;
  logic [45:0]     r_rspSum;
  logic            r_rspValid;

`ifdef ADD45_ARB_RR_EN
  logic [ID_W-1:0] r_rrPtr;
`endif

  logic [ID_W-1:0] w_grant;
  logic            w_grantValid;
  logic [45:0]     w_sum;

  // Grant search. The loop runs from the farthest candidate back to the
  // nearest one so that the last hit, which is the one kept, is the first
  // valid requester at or after the search start.
  always_comb begin
    int idx;
    idx          = 0;
    w_grant      = '0;
    w_grantValid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef ADD45_ARB_RR_EN
      idx = int'(r_rrPtr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
`else
      idx = k;
`endif
      if (i_req_valid[idx]) begin
        w_grant      = ID_W'(idx);
        w_grantValid = 1'b1;
      end
    end
  end

  // Accept is offered only in IDLE. Gating with the reset input keeps the
  // accept low while reset is held even if requesters are already valid.
  always_comb begin
    o_req_ready = '0;
    if ((r_state == IDLE) && w_grantValid && i_rst_n) begin
      o_req_ready[w_grant] = 1'b1;
    end
  end

  // The adder only ever sees registered operands, so its whole ripple path
  // has the EXEC cycle to settle.
  unsignedRippleCarryAdder45bit u_adder (
    .i_a   (r_opA),
    .i_b   ({35'b0, r_opB}),
    .o_sum (w_sum)
  );

  // Sequencer: latch the winner's operands, capture the sum one cycle later,
  // then hold the result until the downstream takes it. Reset discards any
  // transaction in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_opA      <= '0;
      r_opB      <= '0;
      r_opId     <= '0;
      r_rspId    <= '0;
      r_rspSum   <= '0;
      r_rspValid <= 1'b0;
`ifdef ADD45_ARB_RR_EN
      r_rrPtr    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantValid) begin
            r_opA   <= i_req_a[45*int'(w_grant) +: 45];
            r_opB   <= i_req_b[10*int'(w_grant) +: 10];
            r_opId  <= w_grant;
`ifdef ADD45_ARB_RR_EN
            r_rrPtr <= (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : (w_grant + ID_W'(1));
`endif
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_rspSum   <= w_sum;
          r_rspId    <= r_opId;
          r_rspValid <= 1'b1;
          r_state    <= RESP;
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_rspValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_rspValid <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign o_rsp_valid = r_rspValid;
  assign o_rsp_id    = r_rspId;
  assign o_rsp_sum   = r_rspSum;

endmodule

// File: tb/tb_adder45_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder45_arbiter
//
// Directed vector table, hand-written multi-cycle sequences, and a randomized
// phase checked against a transaction-level reference model of the shared
// adder arbiter. Honours ADD45_ARB_RR_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_adder45_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    reqValid;
  logic [NUM_REQ-1:0]    reqReady;
  logic [NUM_REQ*45-1:0] reqA;
  logic [NUM_REQ*10-1:0] reqB;
  logic                  rspValid;
  logic                  rspReady;
  logic [ID_W-1:0]       rspId;
  logic [45:0]           rspSum;

  logic [44:0] opA [NUM_REQ];
  logic [9:0]  opB [NUM_REQ];

  int testsRun;
  int testsFailed;

  bit          mHave;
  int          mAge;
  int          mId;
  logic [45:0] mSum;
  int          mRr;
  int          lastGrant;
  int          cycleCount;
  bit          logging;
  int          logCycle [$];
  logic [NUM_REQ-1:0] logReady [$];

  typedef struct {
    int          id;
    logic [44:0] a;
    logic [9:0]  b;
    logic [45:0] sum;
  } vec_t;

  vec_t vecs [8];

  adder45_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (reqValid),
    .o_req_ready (reqReady),
    .i_req_a     (reqA),
    .i_req_b     (reqB),
    .o_rsp_valid (rspValid),
    .i_rsp_ready (rspReady),
    .o_rsp_id    (rspId),
    .o_rsp_sum   (rspSum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack the per-requester operand arrays onto the DUT's flat buses.
  always_comb begin
    reqA = '0;
    reqB = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      reqA[45*i +: 45] = opA[i];
      reqB[10*i +: 10] = opB[i];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [44:0] randA();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return 45'(r[11:0]);
      default: return r[44:0];
    endcase
  endfunction

  // Reference arbitration: first valid requester found walking upward from
  // the pointer (or from 0 with fixed priority), wrapping around.
  function automatic int modelGrant(input logic [NUM_REQ-1:0] valid);
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
`ifdef ADD45_ARB_RR_EN
      idx = (mRr + k) % NUM_REQ;
`else
      idx = k;
`endif
      if (valid[idx]) return idx;
    end
    return -1;
  endfunction

  // Drive one cycle of requests. Mode 0: random arrivals and random
  // back-pressure. Mode 1: every requester always valid, no back-pressure.
  // Mode 2: no requests, downstream always ready.
  task automatic applyStimulus(input int mode);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mode == 2) begin
        reqValid[i] = 1'b0;
      end else if (mode == 1) begin
        if (!reqValid[i] || lastGrant == i) begin
          opA[i] = randA();
          opB[i] = 10'($urandom());
        end
        reqValid[i] = 1'b1;
      end else begin
        if (lastGrant == i) reqValid[i] = 1'b0;
        if (!reqValid[i] && $urandom_range(0, 3) == 0) begin
          opA[i] = randA();
          opB[i] = 10'($urandom());
          reqValid[i] = 1'b1;
        end
      end
    end
    rspReady = (mode != 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
  endtask

  // Compare DUT against the transaction model for one cycle, then advance
  // both across the clock edge.
  task automatic modelCycle(input string tag);
    int g;
    logic [NUM_REQ-1:0] expReady;
    bit expValid;
    #1;
    g        = mHave ? -1 : modelGrant(reqValid);
    expReady = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
    expValid = mHave && (mAge >= 2);
    checkOutput({tag, " req_ready"}, 64'(reqReady), 64'(expReady));
    checkOutput({tag, " rsp_valid"}, 64'(rspValid), 64'(expValid));
    if (expValid) begin
      checkOutput({tag, " rsp_sum"}, 64'(rspSum), 64'(mSum));
      checkOutput({tag, " rsp_id"}, 64'(rspId), 64'(mId));
    end
    if (logging && reqReady != '0) begin
      logCycle.push_back(cycleCount);
      logReady.push_back(reqReady);
    end
    @(posedge clk);
    cycleCount++;
    lastGrant = g;
    if (g >= 0) begin
      mHave = 1'b1;
      mAge  = 1;
      mId   = g;
      mSum  = 46'(opA[g]) + 46'(opB[g]);
      mRr   = (g + 1) % NUM_REQ;
    end else if (mHave) begin
      if (mAge >= 2 && rspReady) mHave = 1'b0;
      else mAge++;
    end
    #1;
  endtask

  task automatic applyReset();
    rst_n    = 1'b0;
    reqValid = '0;
    rspReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mHave     = 1'b0;
    mAge      = 0;
    mRr       = 0;
    lastGrant = -1;
    @(posedge clk);
    #1;
  endtask

  // Single isolated request with no back-pressure: accept now, result two
  // cycles later, idle again after the handshake.
  task automatic doTransaction(input int id, input logic [44:0] a, input logic [9:0] b,
                               input logic [45:0] expSum, input string name);
    opA[id]      = a;
    opB[id]      = b;
    reqValid     = '0;
    reqValid[id] = 1'b1;
    rspReady     = 1'b1;
    #1;
    checkOutput({name, " accept req_ready"}, 64'(reqReady), 64'(NUM_REQ'(1) << id));
    @(posedge clk);
    #1;
    reqValid[id] = 1'b0;
    #1;
    checkOutput({name, " exec rsp_valid"}, 64'(rspValid), 64'(0));
    checkOutput({name, " exec req_ready"}, 64'(reqReady), 64'(0));
    @(posedge clk);
    #1;
    checkOutput({name, " resp rsp_valid"}, 64'(rspValid), 64'(1));
    checkOutput({name, " resp rsp_sum"}, 64'(rspSum), 64'(expSum));
    checkOutput({name, " resp rsp_id"}, 64'(rspId), 64'(id));
    @(posedge clk);
    #1;
    checkOutput({name, " done rsp_valid"}, 64'(rspValid), 64'(0));
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    rspReady    = 1'b0;
    lastGrant   = -1;
    cycleCount  = 0;
    logging     = 1'b0;
    mHave       = 1'b0;
    mAge        = 0;
    mRr         = 0;
    mId         = 0;
    mSum        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      opA[i] = '0;
      opB[i] = '0;
    end

    vecs[0] = '{0, 45'h1FFF_FFFF_FFFF, 10'h3FF, 46'h2000_0000_03FE};
    vecs[1] = '{1, 45'h0,              10'h001, 46'h1};
    vecs[2] = '{2, 45'h100,            10'h300, 46'h400};
    vecs[3] = '{3, 45'h123,            10'h010, 46'h133};
    vecs[4] = '{1, 45'h0FFF_FFFF_FC00, 10'h3FF, 46'h0FFF_FFFF_FFFF};
    vecs[5] = '{2, 45'h1FFF_FFFF_FFFF, 10'h000, 46'h1FFF_FFFF_FFFF};
    vecs[6] = '{3, 45'h1555_5555_5555, 10'h2AA, 46'h1555_5555_57FF};
    vecs[7] = '{0, 45'h1FFF_FFFF_FC01, 10'h3FF, 46'h2000_0000_0000};

    // Reset values, with every requester already asking.
    reqValid = '1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset req_ready", 64'(reqReady), 64'(0));
    checkOutput("reset rsp_valid", 64'(rspValid), 64'(0));
    checkOutput("reset rsp_sum", 64'(rspSum), 64'(0));
    checkOutput("reset rsp_id", 64'(rspId), 64'(0));
    reqValid = '0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle req_ready", 64'(reqReady), 64'(0));
    checkOutput("idle rsp_valid", 64'(rspValid), 64'(0));

    // Directed vector table.
    for (int v = 0; v < 8; v++) begin
      doTransaction(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sum, $sformatf("vec%0d", v));
    end

    // Back-pressured response with another requester waiting.
    opA[2]   = '0;
    opB[2]   = 10'h001;
    reqValid = 4'b0100;
    rspReady = 1'b0;
    #1;
    checkOutput("bp accept req_ready", 64'(reqReady), 64'(4'b0100));
    @(posedge clk);
    #1;
    reqValid = 4'b0010;
    opA[1]   = 45'hAB_CDEF;
    opB[1]   = 10'h155;
    #1;
    checkOutput("bp exec req_ready", 64'(reqReady), 64'(0));
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp hold%0d rsp_valid", c), 64'(rspValid), 64'(1));
      checkOutput($sformatf("bp hold%0d rsp_sum", c), 64'(rspSum), 64'(1));
      checkOutput($sformatf("bp hold%0d rsp_id", c), 64'(rspId), 64'(2));
      checkOutput($sformatf("bp hold%0d req_ready", c), 64'(reqReady), 64'(0));
      @(posedge clk);
      #1;
    end
    rspReady = 1'b1;
    #1;
    checkOutput("bp release rsp_valid", 64'(rspValid), 64'(1));
    checkOutput("bp release req_ready", 64'(reqReady), 64'(0));
    @(posedge clk);
    #1;
    checkOutput("bp after rsp_valid", 64'(rspValid), 64'(0));
    checkOutput("bp req1 grant", 64'(reqReady), 64'(4'b0010));
    @(posedge clk);
    #1;
    reqValid = '0;
    @(posedge clk);
    #1;
    checkOutput("bp req1 rsp_valid", 64'(rspValid), 64'(1));
    checkOutput("bp req1 rsp_sum", 64'(rspSum), 64'(46'hAB_CF44));
    checkOutput("bp req1 rsp_id", 64'(rspId), 64'(1));
    @(posedge clk);
    #1;

    // Reset asserted between clock edges while the add is in EXEC.
    opA[0]   = 45'h123;
    opB[0]   = 10'h010;
    reqValid = 4'b0001;
    #1;
    checkOutput("rstmid accept req_ready", 64'(reqReady), 64'(4'b0001));
    @(posedge clk);
    #1;
    reqValid = '0;
    rst_n    = 1'b0;
    #1;
    checkOutput("rstmid async rsp_sum", 64'(rspSum), 64'(0));
    checkOutput("rstmid async rsp_valid", 64'(rspValid), 64'(0));
    checkOutput("rstmid async rsp_id", 64'(rspId), 64'(0));
    checkOutput("rstmid async req_ready", 64'(reqReady), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("rstmid quiet%0d rsp_valid", c), 64'(rspValid), 64'(0));
      @(posedge clk);
      #1;
    end
    doTransaction(3, 45'h123, 10'h010, 46'h133, "rstmid fresh");

    // Pointer left at 3, then only requester 0 asks: search must wrap.
    doTransaction(2, 45'h7, 10'h9, 46'h10, "wrap setup");
    doTransaction(0, 45'h100, 10'h300, 46'h400, "wrap");

    // All requesters valid continuously with no back-pressure.
    applyReset();
    cycleCount = 0;
    logging    = 1'b1;
    for (int c = 0; c < 25; c++) begin
      applyStimulus(1);
      modelCycle("allvalid");
    end
    logging = 1'b0;
    checkOutput("allvalid accept count", 64'(logReady.size()), 64'(9));
    for (int k = 0; k < logReady.size(); k++) begin
`ifdef ADD45_ARB_RR_EN
      checkOutput($sformatf("allvalid order%0d", k), 64'(logReady[k]),
                  64'(NUM_REQ'(1) << (k % NUM_REQ)));
`else
      checkOutput($sformatf("allvalid order%0d", k), 64'(logReady[k]), 64'(4'b0001));
`endif
      if (k > 0) begin
        checkOutput($sformatf("allvalid spacing%0d", k), 64'(logCycle[k] - logCycle[k-1]), 64'(3));
      end
    end

    // Random arrivals and back-pressure, then drain.
    for (int c = 0; c < 300; c++) begin
      applyStimulus(0);
      modelCycle("random");
    end
    for (int c = 0; c < 6; c++) begin
      applyStimulus(2);
      modelCycle("drain");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/adder45_arbiter.md
Name: adder45_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 45-bit unsigned ripple-carry adder (unsignedRippleCarryAdder45bit) between NUM_REQ requesters.
Each requester presents a 45-bit A and a 10-bit B. The block grants one request, registers its operands and gives the ripple adder a full cycle. It returns the registered 46-bit sum with the requester ID over a valid/ready response port.
Sits between the partial-product/normalisation stages and the shared wide adder. Exactly one addition is in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  NUM_REQ  per-requester request valid.
req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
req_a  input  NUM_REQ*45  packed A operands; requester i uses bits [45*i+44:45*i].
req_b  input  NUM_REQ*10  packed B operands; requester i uses bits [10*i+9:10*i].
rsp_valid  output  1  result valid.
rsp_ready  input  1  downstream accepts result.
rsp_id  output  ID_W  index of the requester that owns the result.
rsp_sum  output  46  A + zero-extended B.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; rr pointer = 0; req_ready = 0; rsp_valid = 0; rsp_id = 0; rsp_sum = 0; operand registers = 0.
- Arithmetic:
  - rsp_sum = {1'b0, A} + {36'b0, B}, full 46 bits, never overflows.
  - B is zero-extended to 45 bits at the adder input.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. It goes to the first requester with req_valid=1, searching from the rr pointer upward and wrapping modulo NUM_REQ.
  - req_ready[grant] = 1 in the same cycle; all other req_ready bits are 0.
  - If no req_valid is high: req_ready = 0 and the FSM stays in IDLE.
  - On accept (req_valid[g] & req_ready[g]):
    - latch A, B and g into the operand/ID registers;
    - rr pointer <= (g+1) mod NUM_REQ;
    - next state = EXEC.
- EXEC:
  - req_ready = 0.
  - The adder computes from the operand registers.
  - At the clock edge: rsp_sum <= adder output; rsp_id <= latched g; next state = RESP.
- RESP:
  - rsp_valid = 1; rsp_sum and rsp_id are held stable.
  - On rsp_ready = 1: rsp_valid drops on the next edge and the FSM returns to IDLE.
  - While rsp_ready = 0: the FSM stays in RESP indefinitely.
- Latency and throughput:
  - Accept in cycle N gives rsp_valid high in cycle N+2.
  - The next accept is possible no earlier than one cycle after the response handshake.
  - Best-case throughput is one addition per 3 cycles.
- req_ready is never high outside IDLE. Requesters hold req_valid and operands until accepted; a requester that drops req_valid before acceptance is simply skipped.
- Simultaneous requests: exactly one is granted per IDLE cycle. The others keep waiting with req_ready = 0.
- Grant search wraps: with rr = NUM_REQ-1 and only requester 0 valid, requester 0 is granted.
- Reset mid-operation (EXEC or RESP): the in-flight result is discarded, all outputs return to reset values immediately and no response is issued.
- Responses are not reordered; only one transaction exists at a time.

Optional Feature:
ADD45_ARB_RR_EN:
- Defined: round-robin arbitration exactly as described in Behaviour.
- Undefined: fixed priority. The lowest-index valid requester always wins, the rr pointer register is not implemented, and all other timing is unchanged.

Test Plan:
1. Reset, then req0 with A=45'h1FFF_FFFF_FFFF, B=10'h3FF, rsp_ready=1 -> req_ready[0] high in the accept cycle; 2 cycles later rsp_valid=1, rsp_sum=46'h2000_0000_03FE, rsp_id=0.
2. req2 with A=0, B=10'h001 and rsp_ready held 0 for 5 cycles -> rsp_valid stays 1 with rsp_sum=1, rsp_id=2 stable. No req_ready is asserted while req1 is also valid. req1 is granted in the cycle after rsp_ready rises.
3. All four requesters valid continuously, rsp_ready=1 (RR_EN defined) -> grant order 0,1,2,3,0, one accept every 3 cycles; each response carries the matching id and sum.
4. Same stimulus as test 3 with RR_EN undefined -> requester 0 is granted on every accept; requesters 1..3 are never granted while req0 stays valid.
5. Assert rst_n=0 in the EXEC cycle of a request with A=45'h123, B=10'h10 -> outputs clear asynchronously and no rsp_valid occurs. After release, a fresh request returns the correct sum.
6. rr=3 with only req0 valid, A=45'h0_0000_0100, B=10'h300 -> req0 granted (wrap); rsp_sum=46'h400, rsp_id=0.
